// File: rtl/mips_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM
// states, default datapath width and small op-decode helpers.
package mips_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Signed ops take magnitudes on entry and sign-correct on exit
  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One iteration of the shared multiply/divide datapath.
// Ports:
//   div_mode      : 0 = shift-add multiply step, 1 = restoring divide step
//   acc, sh       : current {upper product, lower product/multiplier} or
//                   {partial remainder, dividend/quotient} registers
//   opnd          : multiplicand (multiply) or divisor (divide)
//   acc_next/sh_next : register values after this iteration
module muldiv_iter_core
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] sh,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] sh_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Multiply: add multiplicand into the upper half when LSB set, carry kept
  assign sum = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : '0);

  // Divide: bring next dividend bit into the remainder. The partial
  // remainder is always below the divisor, so a successful subtract
  // result always fits back into WIDTH bits.
  assign shifted = {acc, sh[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, opnd});
  assign diff    = shifted[WIDTH-1:0] - opnd;

  always_comb begin
    acc_next = sum[WIDTH:1];
    sh_next  = {sum[0], sh[WIDTH-1:1]};
    if (div_mode) begin
      if (fits) begin
        acc_next = diff;
        sh_next  = {sh[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        sh_next  = {sh[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO
// registers. Runs WIDTH iterations then one fix-up cycle.
// Ports:
//   Clk, Reset      : clock, asynchronous active-high reset
//   Start, Op, A, B : operation request (accepted only in IDLE)
//   HiWe, LoWe, WData : MTHI/MTLO writes (IDLE only, Start has priority)
//   Busy            : operation in flight (combinational from state)
//   Done            : one-cycle pulse after HI/LO writeback
//   Hi, Lo          : HI/LO registers
module hilo_muldiv_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWe,
  input  logic             LoWe,
  input  logic [WIDTH-1:0] WData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned     PW   = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state, state_d;
  logic [CNT_W-1:0] count, count_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             done_d;

  // Request decode and operand magnitudes
  op_e              op_in;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign op_in  = op_e'(Op);
  assign sign_a = op_is_signed(op_in) & A[WIDTH-1];
  assign sign_b = op_is_signed(op_in) & B[WIDTH-1];
  assign abs_a  = sign_a ? (~A + WIDTH'(1)) : A;
  assign abs_b  = sign_b ? (~B + WIDTH'(1)) : B;

  // Per-cycle datapath step
  logic [WIDTH-1:0] acc_step, sh_step;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .div_mode (op_is_div(op_q)),
    .acc      (acc_q),
    .sh       (sh_q),
    .opnd     (opnd_q),
    .acc_next (acc_step),
    .sh_next  (sh_step)
  );

  // Sign-corrected results for the fix-up cycle
  logic [PW-1:0]    prod_raw, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign prod_raw = {acc_q, sh_q};
  assign prod_fix = neg_res_q ? (~prod_raw + PW'(1)) : prod_raw;
  assign quo_fix  = neg_res_q ? (~sh_q + WIDTH'(1)) : sh_q;
  assign rem_fix  = neg_rem_q ? (~acc_q + WIDTH'(1)) : acc_q;

  assign Busy = (state != IDLE);

  // Next-state and next-register logic
  always_comb begin
    state_d   = state;
    count_d   = count;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    hi_d      = Hi;
    lo_d      = Lo;
    done_d    = 1'b0;

    unique case (state)
      IDLE: begin
        if (Start) begin
          op_d      = op_in;
          acc_d     = '0;
          // Divide: shift register holds dividend; multiply: the multiplier
          sh_d      = op_is_div(op_in) ? abs_a : abs_b;
          opnd_d    = op_is_div(op_in) ? abs_b : abs_a;
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          dbz_d     = (B == '0);
          count_d   = '0;
          state_d   = CALC;
        end else begin
          if (HiWe) hi_d = WData;
          if (LoWe) lo_d = WData;
        end
      end

      CALC: begin
        acc_d   = acc_step;
        sh_d    = sh_step;
        count_d = count + CNT_W'(1);
        if (count == LAST) state_d = FIX;
      end

      FIX: begin
        if (!op_is_div(op_q)) begin
          hi_d = prod_fix[PW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dbz_q) begin
          // Remainder already equals |A|; restoring its sign gives A back
          hi_d = rem_fix;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      count     <= '0;
      op_q      <= OP_MULT;
      opnd_q    <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
      Done      <= 1'b0;
    end else begin
      state     <= state_d;
      count     <= count_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      Hi        <= hi_d;
      Lo        <= lo_d;
      Done      <= done_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: stimulus pushes expected HI/LO,
// a negedge monitor pops and compares on every Done pulse.
module tb_hilo_muldiv_unit;
  import mips_pkg::*;

  localparam int unsigned W = 32;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic [1:0]   Op = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         HiWe = 1'b0;
  logic         LoWe = 1'b0;
  logic [W-1:0] WData = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  res_t         sb_q[$];
  int           n_vec = 0;
  int           n_bad = 0;
  int           done_cnt = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 Clk = ~Clk;

  hilo_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .HiWe  (HiWe),
    .LoWe  (LoWe),
    .WData (WData),
    .Busy  (Busy),
    .Done  (Done),
    .Hi    (Hi),
    .Lo    (Lo)
  );

  task automatic check32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding request
  always @(negedge Clk) begin
    res_t e;
    if (!Reset && Done === 1'b1) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL done_unexpected: Done high with nothing pending at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        check32("hi_result", Hi, e.hi);
        check32("lo_result", Lo, e.lo);
      end
    end
  end

  // Issue one op at the current negedge and wait for it to retire.
  // inj > 0: at that busy cycle try Start + MTHI, both must be ignored.
  // lowe:    assert MTLO together with Start, the write must be dropped.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el,
                        input int inj, input logic lowe);
    int   busy_n;
    int   d0;
    res_t e;
    e.hi = eh;
    e.lo = el;
    sb_q.push_back(e);
    d0    = done_cnt;
    Op    = op;
    A     = a;
    B     = b;
    Start = 1'b1;
    if (lowe) begin
      LoWe  = 1'b1;
      WData = 32'h0000_5555;
    end
    @(negedge Clk);
    Start = 1'b0;
    LoWe  = 1'b0;
    A     = $urandom;
    B     = $urandom;
    if (lowe) check32("lo_write_with_start", Lo, m_lo);
    busy_n = 0;
    while (Busy === 1'b1 && busy_n < 100) begin
      busy_n++;
      if (busy_n == inj) begin
        Start = 1'b1;
        Op    = OP_MULTU;
        A     = 32'd100;
        B     = 32'd100;
        HiWe  = 1'b1;
        WData = 32'h0000_AAAA;
      end
      @(negedge Clk);
      if (busy_n == inj) begin
        Start = 1'b0;
        HiWe  = 1'b0;
        check32("hi_write_while_busy", Hi, m_hi);
      end
    end
    check32("busy_cycles", W'(busy_n), 32'd33);
    m_hi = eh;
    m_lo = el;
    @(negedge Clk);
    check32("done_pulses", W'(done_cnt - d0), 32'd1);
    check32("hi_hold", Hi, eh);
    check32("lo_hold", Lo, el);
  endtask

  initial begin
    int d0;
    @(negedge Clk);
    @(negedge Clk);
    check32("reset_busy", W'(Busy), 32'd0);
    check32("reset_done", W'(Done), 32'd0);
    check32("reset_hi", Hi, 32'd0);
    check32("reset_lo", Lo, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // MTHI + MTLO together, then MTHI alone
    HiWe = 1'b1; LoWe = 1'b1; WData = 32'hDEAD_BEEF;
    @(negedge Clk);
    HiWe = 1'b0; LoWe = 1'b0;
    check32("mthi_mtlo_hi", Hi, 32'hDEAD_BEEF);
    check32("mthi_mtlo_lo", Lo, 32'hDEAD_BEEF);
    HiWe = 1'b1; WData = 32'h1234_5678;
    @(negedge Clk);
    HiWe = 1'b0;
    check32("mthi_hi", Hi, 32'h1234_5678);
    check32("mthi_lo_keep", Lo, 32'hDEAD_BEEF);
    m_hi = 32'h1234_5678;
    m_lo = 32'hDEAD_BEEF;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1'b0);
    run_op(OP_MULT,  32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6, 0, 1'b0);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 1'b0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b0);
    run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 1'b0);
    run_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        0, 1'b0);
    run_op(OP_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(OP_DIV,   32'h8000_0000, 32'd0,         32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 1'b0);

    // Start + MTHI mid-operation ignored, then Start + MTLO in IDLE
    run_op(OP_MULTU, 32'd3,  32'd5,  32'd0, 32'd15,    10, 1'b0);
    run_op(OP_MULTU, 32'd16, 32'd16, 32'd0, 32'h100,   0,  1'b1);

    // Asynchronous reset in the middle of a DIV
    m_hi = 32'hCAFE_0001;
    HiWe = 1'b1; WData = m_hi;
    @(negedge Clk);
    HiWe = 1'b0;
    check32("pre_reset_hi", Hi, 32'hCAFE_0001);
    d0 = done_cnt;
    Op = OP_DIV; A = 32'hFFFF_FF9C; B = 32'd3; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (14) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check32("abort_busy", W'(Busy), 32'd0);
    check32("abort_hi", Hi, 32'd0);
    check32("abort_lo", Lo, 32'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (40) @(negedge Clk);
    check32("abort_no_done", W'(done_cnt - d0), 32'd0);
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 1'b0);

    check32("scoreboard_empty", W'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish at %0t", $time);
    $fatal(1);
  end

endmodule
